// File: rtl/serial_tx.sv
// serial_tx: frames a parallel word as START(0), WIDTH data bits LSB first and
// STOP(1), holding every serial bit for CLKS_PER_BIT clocks. The line idles
// high. A new word is taken only in IDLE. done marks the first IDLE cycle
// after a completed frame, so a requester that keeps valid_in high chains
// frames with the least possible gap.
module serial_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   // The cycle counter must be able to represent CLKS_PER_BIT-1 for every
   // legal value, including CLKS_PER_BIT=1, where it stays at zero.
   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   // The bit counter spans 0..WIDTH-1 and is never narrower than one bit.
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] shift_r;
   logic [BIT_W-1:0] bit_cnt_r;
   logic [CNT_W-1:0] clk_cnt_r;

   logic             bit_end_s;
   logic [WIDTH-1:0] shift_next_s;

   // Acceptance depends on the state register alone, so ready decodes it directly.
   assign ready = (state_r == ST_IDLE);

   // Marks the last clock of the current bit period and forms the shifted data word.
   always_comb begin
      bit_end_s    = 1'b0;
      shift_next_s = shift_r >> 1;
      if (clk_cnt_r == LAST_CNT) begin
         bit_end_s = 1'b1;
      end else begin
         bit_end_s = 1'b0;
      end
   end

   // Frame sequencer: state, counters, shift register and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         shift_r   <= {WIDTH{1'b0}};
         bit_cnt_r <= {BIT_W{1'b0}};
         clk_cnt_r <= {CNT_W{1'b0}};
         ser_out   <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               clk_cnt_r <= {CNT_W{1'b0}};
               bit_cnt_r <= {BIT_W{1'b0}};
               if (valid_in) begin
                  // The word is captured here; later changes on data_in are ignored.
                  shift_r <= data_in;
                  ser_out <= 1'b0;
                  busy    <= 1'b1;
                  state_r <= ST_START;
               end else begin
                  ser_out <= 1'b1;
                  busy    <= 1'b0;
               end
            end

            ST_START: begin
               if (bit_end_s) begin
                  clk_cnt_r <= {CNT_W{1'b0}};
                  ser_out   <= shift_r[0];
                  state_r   <= ST_DATA;
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_W'(1);
               end
            end

            ST_DATA: begin
               if (bit_end_s) begin
                  clk_cnt_r <= {CNT_W{1'b0}};
                  shift_r   <= shift_next_s;
                  if (bit_cnt_r == LAST_BIT) begin
                     bit_cnt_r <= {BIT_W{1'b0}};
                     ser_out   <= 1'b1;
                     state_r   <= ST_STOP;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                     ser_out   <= shift_next_s[0];
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_W'(1);
               end
            end

            ST_STOP: begin
               ser_out <= 1'b1;
               if (bit_end_s) begin
                  clk_cnt_r <= {CNT_W{1'b0}};
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_r   <= ST_IDLE;
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_W'(1);
               end
            end

            default: begin
               state_r   <= ST_IDLE;
               shift_r   <= {WIDTH{1'b0}};
               bit_cnt_r <= {BIT_W{1'b0}};
               clk_cnt_r <= {CNT_W{1'b0}};
               ser_out   <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: one instance with default parameters and one fast
// instance (WIDTH=4, CLKS_PER_BIT=1). Expected line behaviour comes from a
// slot-based model: within a frame, cycle k falls into bit slot k/CLKS_PER_BIT,
// where slot 0 is START, slots 1..WIDTH are the data bits LSB first, and the
// last slot is STOP. done follows (WIDTH+2)*CLKS_PER_BIT cycles after acceptance.
// Observed vectors are {ser_out, done, busy, ready}.
module tb_serial_tx;

   localparam int A_W = 8;
   localparam int A_C = 4;
   localparam int A_L = (A_W + 2) * A_C;
   localparam int B_W = 4;
   localparam int B_C = 1;
   localparam int B_L = (B_W + 2) * B_C;

   logic           clk;
   logic           rst_a;
   logic           rst_b;
   logic [A_W-1:0] a_data;
   logic           a_valid;
   logic           a_ready;
   logic           a_ser;
   logic           a_busy;
   logic           a_done;
   logic [B_W-1:0] b_data;
   logic           b_valid;
   logic           b_ready;
   logic           b_ser;
   logic           b_busy;
   logic           b_done;

   int total = 0;
   int bad   = 0;

   serial_tx #(.WIDTH(A_W), .CLKS_PER_BIT(A_C)) dut_a (
      .clk      (clk),
      .rst      (rst_a),
      .data_in  (a_data),
      .valid_in (a_valid),
      .ready    (a_ready),
      .ser_out  (a_ser),
      .busy     (a_busy),
      .done     (a_done)
   );

   serial_tx #(.WIDTH(B_W), .CLKS_PER_BIT(B_C)) dut_b (
      .clk      (clk),
      .rst      (rst_b),
      .data_in  (b_data),
      .valid_in (b_valid),
      .ready    (b_ready),
      .ser_out  (b_ser),
      .busy     (b_busy),
      .done     (b_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected serial level at cycle k of a frame (k=0 is the cycle after acceptance).
   function automatic logic model_bit(input logic [31:0] word, input int w, input int c, input int k);
      int slot;
      slot = k / c;
      if (slot == 0) return 1'b0;
      else if (slot <= w) return word[slot-1];
      else return 1'b1;
   endfunction

   // Expected {ser_out, done, busy, ready} at cycle k; k equal to the frame length is the done cycle.
   function automatic logic [3:0] exp_frame(input logic [31:0] word, input int w, input int c, input int k);
      if (k < (w + 2) * c) return {model_bit(word, w, c, k), 1'b0, 1'b1, 1'b0};
      else return 4'b1101;
   endfunction

   task automatic test_reset;
      rst_a = 1'b1; rst_b = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0;
      a_data = 8'h00; b_data = 4'h0;
      repeat (3) @(negedge clk);
      total++;
      if ({a_ser, a_done, a_busy, a_ready} !== 4'b1001) begin
         bad++; $display("FAIL reset_a got=%b exp=%b", {a_ser, a_done, a_busy, a_ready}, 4'b1001);
      end
      total++;
      if ({b_ser, b_done, b_busy, b_ready} !== 4'b1001) begin
         bad++; $display("FAIL reset_b got=%b exp=%b", {b_ser, b_done, b_busy, b_ready}, 4'b1001);
      end
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({a_ser, a_done, a_busy, a_ready, b_ser, b_done, b_busy, b_ready} !== 8'b1001_1001) begin
         bad++; $display("FAIL idle_after_reset got=%b exp=%b",
                         {a_ser, a_done, a_busy, a_ready, b_ser, b_done, b_busy, b_ready}, 8'b1001_1001);
      end
   endtask

   task automatic test_frame_a5;
      logic [3:0] exp;
      a_data = 8'hA5; a_valid = 1'b1;
      for (int k = 0; k <= A_L; k++) begin
         @(negedge clk);
         exp = exp_frame(32'h0000_00A5, A_W, A_C, k);
         total++;
         if ({a_ser, a_done, a_busy, a_ready} !== exp) begin
            bad++; $display("FAIL frame_a5 k=%0d got=%b exp=%b", k, {a_ser, a_done, a_busy, a_ready}, exp);
         end
         // New data after acceptance must not disturb the frame.
         if (k == 0) begin a_valid = 1'b0; a_data = 8'h5A; end
      end
      @(negedge clk);
      total++;
      if ({a_ser, a_done, a_busy, a_ready} !== 4'b1001) begin
         bad++; $display("FAIL frame_a5_after got=%b exp=%b", {a_ser, a_done, a_busy, a_ready}, 4'b1001);
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] exp_q[$];
      for (int k = 0; k <= A_L; k++) exp_q.push_back(exp_frame(32'h0000_003C, A_W, A_C, k));
      for (int k = 0; k <= A_L; k++) exp_q.push_back(exp_frame(32'h0000_00FF, A_W, A_C, k));
      a_data = 8'h3C; a_valid = 1'b1;
      for (int n = 0; n < exp_q.size(); n++) begin
         @(negedge clk);
         total++;
         if ({a_ser, a_done, a_busy, a_ready} !== exp_q[n]) begin
            bad++; $display("FAIL back_to_back n=%0d got=%b exp=%b", n, {a_ser, a_done, a_busy, a_ready}, exp_q[n]);
         end
         if (n == 0) a_data = 8'hFF;
         if (n == A_L + 1) a_valid = 1'b0;
      end
      @(negedge clk);
      total++;
      if ({a_ser, a_done, a_busy, a_ready} !== 4'b1001) begin
         bad++; $display("FAIL back_to_back_after got=%b exp=%b", {a_ser, a_done, a_busy, a_ready}, 4'b1001);
      end
   endtask

   task automatic test_ignore_busy;
      logic [31:0] word;
      logic [3:0]  exp;
      word = $urandom & 32'h0000_00FF;
      a_data = word[7:0]; a_valid = 1'b1;
      for (int k = 0; k <= A_L; k++) begin
         @(negedge clk);
         exp = exp_frame(word, A_W, A_C, k);
         total++;
         if ({a_ser, a_done, a_busy, a_ready} !== exp) begin
            bad++; $display("FAIL ignore_busy k=%0d got=%b exp=%b", k, {a_ser, a_done, a_busy, a_ready}, exp);
         end
         if (k == 0) a_valid = 1'b0;
         if (k == 8) begin a_valid = 1'b1; a_data = 8'h00; end
         if (k == A_L - 1) a_valid = 1'b0;
      end
      @(negedge clk);
      total++;
      if ({a_ser, a_done, a_busy, a_ready} !== 4'b1001) begin
         bad++; $display("FAIL ignore_busy_after got=%b exp=%b", {a_ser, a_done, a_busy, a_ready}, 4'b1001);
      end
   endtask

   task automatic test_rst_mid_frame;
      logic [31:0] word;
      logic [3:0]  exp;
      word = $urandom & 32'h0000_00FF;
      a_data = word[7:0]; a_valid = 1'b1;
      for (int k = 0; k <= 17; k++) begin
         @(negedge clk);
         exp = exp_frame(word, A_W, A_C, k);
         total++;
         if ({a_ser, a_done, a_busy, a_ready} !== exp) begin
            bad++; $display("FAIL rst_mid_pre k=%0d got=%b exp=%b", k, {a_ser, a_done, a_busy, a_ready}, exp);
         end
         if (k == 0) a_valid = 1'b0;
      end
      // Cycles 16..19 carry data bit 3; reset lands in the middle of it.
      rst_a = 1'b1;
      @(negedge clk);
      total++;
      if ({a_ser, a_done, a_busy, a_ready} !== 4'b1001) begin
         bad++; $display("FAIL rst_mid_next got=%b exp=%b", {a_ser, a_done, a_busy, a_ready}, 4'b1001);
      end
      rst_a = 1'b0;
      for (int n = 0; n < A_L + 4; n++) begin
         @(negedge clk);
         total++;
         if ({a_ser, a_done, a_busy, a_ready} !== 4'b1001) begin
            bad++; $display("FAIL rst_mid_quiet n=%0d got=%b exp=%b", n, {a_ser, a_done, a_busy, a_ready}, 4'b1001);
         end
      end
   endtask

   task automatic test_rst_with_valid;
      rst_a = 1'b1; a_valid = 1'b1; a_data = 8'($urandom);
      @(negedge clk);
      total++;
      if ({a_ser, a_done, a_busy, a_ready} !== 4'b1001) begin
         bad++; $display("FAIL rst_valid got=%b exp=%b", {a_ser, a_done, a_busy, a_ready}, 4'b1001);
      end
      rst_a = 1'b0; a_valid = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         total++;
         if ({a_ser, a_done, a_busy, a_ready} !== 4'b1001) begin
            bad++; $display("FAIL rst_valid_quiet n=%0d got=%b exp=%b", n, {a_ser, a_done, a_busy, a_ready}, 4'b1001);
         end
      end
   endtask

   task automatic test_fast_config;
      logic [5:0]  seq;
      logic [3:0]  exp;
      logic [31:0] words[5];
      seq = 6'b110010;
      b_data = 4'b1001; b_valid = 1'b1;
      for (int k = 0; k <= B_L; k++) begin
         @(negedge clk);
         exp = (k < B_L) ? {seq[k], 1'b0, 1'b1, 1'b0} : 4'b1101;
         total++;
         if ({b_ser, b_done, b_busy, b_ready} !== exp) begin
            bad++; $display("FAIL fast_1001 k=%0d got=%b exp=%b", k, {b_ser, b_done, b_busy, b_ready}, exp);
         end
         if (k == 0) b_valid = 1'b0;
      end
      @(negedge clk);
      total++;
      if ({b_ser, b_done, b_busy, b_ready} !== 4'b1001) begin
         bad++; $display("FAIL fast_after got=%b exp=%b", {b_ser, b_done, b_busy, b_ready}, 4'b1001);
      end
      // Chained random frames with valid held high throughout.
      for (int i = 0; i < 5; i++) words[i] = $urandom & 32'h0000_000F;
      b_data = words[0][3:0]; b_valid = 1'b1;
      for (int f = 0; f < 5; f++) begin
         for (int k = 0; k <= B_L; k++) begin
            @(negedge clk);
            exp = exp_frame(words[f], B_W, B_C, k);
            total++;
            if ({b_ser, b_done, b_busy, b_ready} !== exp) begin
               bad++; $display("FAIL fast_chain f=%0d k=%0d got=%b exp=%b", f, k, {b_ser, b_done, b_busy, b_ready}, exp);
            end
            if (k == 0) b_data = (f < 4) ? words[f+1][3:0] : 4'($urandom);
            if (k == B_L && f == 4) b_valid = 1'b0;
         end
      end
      @(negedge clk);
      total++;
      if ({b_ser, b_done, b_busy, b_ready} !== 4'b1001) begin
         bad++; $display("FAIL fast_chain_after got=%b exp=%b", {b_ser, b_done, b_busy, b_ready}, 4'b1001);
      end
   endtask

   task automatic test_random;
      logic [31:0] word;
      logic [3:0]  exp;
      bit          chain;
      int          gap;
      chain = 1'b0;
      word  = $urandom & 32'h0000_00FF;
      for (int f = 0; f < 8; f++) begin
         if (!chain) begin
            @(negedge clk);
            total++;
            if ({a_ser, a_done, a_busy, a_ready} !== 4'b1001) begin
               bad++; $display("FAIL random_idle f=%0d got=%b exp=%b", f, {a_ser, a_done, a_busy, a_ready}, 4'b1001);
            end
            a_data = word[7:0]; a_valid = 1'b1;
         end
         for (int k = 0; k <= A_L; k++) begin
            @(negedge clk);
            exp = exp_frame(word, A_W, A_C, k);
            total++;
            if ({a_ser, a_done, a_busy, a_ready} !== exp) begin
               bad++; $display("FAIL random f=%0d k=%0d got=%b exp=%b", f, k, {a_ser, a_done, a_busy, a_ready}, exp);
            end
            // Requests offered mid-frame are noise that must be ignored.
            if (k < A_L) begin
               a_valid = 1'($urandom_range(0, 1));
               a_data  = 8'($urandom);
            end
         end
         chain = ($urandom_range(0, 1) == 1) && (f < 7);
         word  = $urandom & 32'h0000_00FF;
         if (chain) begin
            a_data = word[7:0]; a_valid = 1'b1;
         end else begin
            a_valid = 1'b0;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
         end
      end
      a_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({a_ser, a_done, a_busy, a_ready} !== 4'b1001) begin
         bad++; $display("FAIL random_after got=%b exp=%b", {a_ser, a_done, a_busy, a_ready}, 4'b1001);
      end
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_back_to_back();
      test_ignore_busy();
      test_rst_mid_frame();
      test_rst_with_valid();
      test_fast_config();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
